// File: rtl/instr_fetch.sv
// Prefetch FIFO: flushable ring buffer; the head reads as zero while empty.
// Latency: a pushed word is visible at the head on the cycle after the push.
// Backpressure: the caller must not push when full; push and pop may coincide.
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_vld,
  output logic [W-1:0]             head_dat
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_dat;
        wr_d        = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign count    = cnt_q;
  assign head_vld = (cnt_q != '0);
  assign head_dat = head_vld ? mem_q[rd_q] : '0;
endmodule

// Instruction fetch: owns the PC, reads a synchronous ROM, buffers words for Decode.
// Latency: request in cycle 0, word pushed at the end of cycle 1, out_valid in cycle 2.
// Backpressure: requests issue only while FIFO slots cover every in-flight word.
module instr_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          AW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [AW-1:0] out_pc,
  input  logic          branch_taken,
  input  logic [31:0]   branch_delta,
  input  logic [AW-1:0] branch_base_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] PC_INIT = AW'(RESET_PC) & ~AW'(3);

  logic [AW-1:0]    pc_q, pc_d;
  logic [AW-1:0]    tag_q, tag_d;
  logic             inflight_q, inflight_d;
  logic [CW-1:0]    fifo_count;
  logic             head_vld;
  logic [31+AW:0]   head_dat;
  logic             pop;
  logic             push;
  logic [CW:0]      used;
  logic [AW-1:0]    target;

  assign out_valid = head_vld && !branch_taken;
  assign pop       = out_valid && out_ready;
  assign push      = inflight_q && !branch_taken;

  // A same-cycle pop frees its slot in time for the next response; this is
  // what sustains one instruction per cycle with only two entries.
  assign used     = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign imem_req = !rst && !branch_taken && (used < (CW+1)'(DEPTH));
  assign imem_addr = pc_q;

  assign target = branch_base_pc + AW'($signed({branch_delta, 2'b00}));

  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    if (branch_taken) begin
      pc_d = target & ~AW'(3);
    end else if (imem_req) begin
      pc_d       = pc_q + AW'(4);
      tag_d      = pc_q;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= PC_INIT;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .W     (32 + AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (branch_taken),
    .push     (push),
    .push_dat ({imem_rdata, tag_q}),
    .pop      (pop),
    .count    (fifo_count),
    .head_vld (head_vld),
    .head_dat (head_dat)
  );

  assign out_instr = head_dat[31+AW:AW];
  assign out_pc    = head_dat[AW-1:0];
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, branches, async reset.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        branch_taken;
  logic [31:0] branch_delta;
  logic [31:0] branch_base_pc;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch #(.DEPTH(2), .RESET_PC(32'h0), .AW(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .branch_taken   (branch_taken),
    .branch_delta   (branch_delta),
    .branch_base_pc (branch_base_pc)
  );

  always #5 clk = ~clk;

  // ROM contents: word i holds 0xA000_0000 + i
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= 32'hA000_0000 + (imem_addr >> 2);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drive point at edge+1; caller checks after a further #1
  task automatic edge_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    out_ready = rdy;
    branch_taken = 1'b0;
    branch_delta = 32'h0;
    branch_base_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic branch(input logic [31:0] base, input logic [31:0] delta);
    edge_drive();
    branch_taken = 1'b1;
    branch_base_pc = base;
    branch_delta = delta;
    #1;
  endtask

  task automatic branch_off();
    edge_drive();
    branch_taken = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    branch_taken = 1'b0;
    branch_delta = 32'h0;
    branch_base_pc = 32'h0;
    #2;
    chk("rst_req",   32'(imem_req),  32'd0);
    chk("rst_addr",  imem_addr,      32'h0);
    chk("rst_vld",   32'(out_valid), 32'd0);
    chk("rst_instr", out_instr,      32'h0);
    chk("rst_pc",    out_pc,         32'h0);

    // Streaming
    do_reset(1'b1);
    chk("s0_req",  32'(imem_req),  32'd1);
    chk("s0_addr", imem_addr,      32'h0);
    chk("s0_vld",  32'(out_valid), 32'd0);
    step();
    chk("s1_addr", imem_addr,      32'h4);
    chk("s1_vld",  32'(out_valid), 32'd0);
    for (int k = 2; k <= 6; k++) begin
      step();
      chk("s_vld",   32'(out_valid), 32'd1);
      chk("s_pc",    out_pc,         32'(4 * (k - 2)));
      chk("s_instr", out_instr,      32'hA000_0000 + 32'(k - 2));
      chk("s_req",   32'(imem_req),  32'd1);
    end

    // Forward branch with a read in flight and a non-empty FIFO under out_ready=1
    branch(32'h10, 32'd5);
    chk("bf_vld", 32'(out_valid), 32'd0);
    chk("bf_req", 32'(imem_req),  32'd0);
    branch_off();
    chk("bf1_req",  32'(imem_req),  32'd1);
    chk("bf1_addr", imem_addr,      32'h24);
    chk("bf1_vld",  32'(out_valid), 32'd0);
    chk("bf1_pc",   out_pc,         32'h0);
    step();
    chk("bf2_vld",  32'(out_valid), 32'd0);
    chk("bf2_addr", imem_addr,      32'h28);
    step();
    chk("bf3_vld",   32'(out_valid), 32'd1);
    chk("bf3_pc",    out_pc,         32'h24);
    chk("bf3_instr", out_instr,      32'hA000_0009);
    step();
    chk("bf4_pc",    out_pc,         32'h28);
    chk("bf4_instr", out_instr,      32'hA000_000A);

    // Backward branch wrapping below zero
    branch(32'h4, 32'hFFFF_FFFE);
    chk("bw_vld", 32'(out_valid), 32'd0);
    branch_off();
    chk("bw1_req",  32'(imem_req), 32'd1);
    chk("bw1_addr", imem_addr,     32'hFFFF_FFFC);
    step();
    chk("bw2_addr", imem_addr,     32'h0);
    step();
    chk("bw3_pc",    out_pc,    32'hFFFF_FFFC);
    chk("bw3_instr", out_instr, 32'hDFFF_FFFF);
    step();
    chk("bw4_pc",    out_pc,    32'h0);
    chk("bw4_instr", out_instr, 32'hA000_0000);

    // Back-to-back branches: the second one wins
    branch(32'h100, 32'd0);
    branch(32'h200, 32'd1);
    chk("bb_vld", 32'(out_valid), 32'd0);
    branch_off();
    chk("bb1_addr", imem_addr, 32'h204);
    step();
    step();
    chk("bb3_vld",   32'(out_valid), 32'd1);
    chk("bb3_pc",    out_pc,         32'h204);
    chk("bb3_instr", out_instr,      32'hA000_0081);

    // Unaligned branch target
    branch(32'h33, 32'd0);
    branch_off();
    chk("ua1_addr", imem_addr, 32'h30);
    step();
    step();
    chk("ua3_pc",    out_pc,    32'h30);
    chk("ua3_instr", out_instr, 32'hA000_000C);

    // Async reset for half a cycle mid-stream
    edge_drive();
    rst = 1'b1;
    #1;
    chk("ar_vld",   32'(out_valid), 32'd0);
    chk("ar_pc",    out_pc,         32'h0);
    chk("ar_instr", out_instr,      32'h0);
    chk("ar_req",   32'(imem_req),  32'd0);
    chk("ar_addr",  imem_addr,      32'h0);
    #3;
    rst = 1'b0;
    #1;
    chk("ar0_req",  32'(imem_req),  32'd1);
    chk("ar0_addr", imem_addr,      32'h0);
    step();
    chk("ar1_vld",  32'(out_valid), 32'd0);
    chk("ar1_addr", imem_addr,      32'h4);
    step();
    chk("ar2_vld",   32'(out_valid), 32'd1);
    chk("ar2_pc",    out_pc,         32'h0);
    chk("ar2_instr", out_instr,      32'hA000_0000);

    // Backpressure: Decode stalls from the start
    do_reset(1'b0);
    chk("bp0_req", 32'(imem_req), 32'd1);
    step();
    chk("bp1_req", 32'(imem_req), 32'd1);
    step();
    chk("bp2_vld",  32'(out_valid), 32'd1);
    chk("bp2_pc",   out_pc,         32'h0);
    chk("bp2_req",  32'(imem_req),  32'd0);
    chk("bp2_addr", imem_addr,      32'h8);
    step();
    chk("bp3_req",   32'(imem_req), 32'd0);
    chk("bp3_instr", out_instr,     32'hA000_0000);
    step();
    chk("bp4_req",   32'(imem_req), 32'd0);
    chk("bp4_addr",  imem_addr,     32'h8);
    chk("bp4_instr", out_instr,     32'hA000_0000);
    edge_drive();
    out_ready = 1'b1;
    #1;
    chk("bp5_pc",  out_pc,        32'h0);
    chk("bp5_req", 32'(imem_req), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("bp_vld",   32'(out_valid), 32'd1);
      chk("bp_pc",    out_pc,         32'(4 * k));
      chk("bp_instr", out_instr,      32'hA000_0000 + 32'(k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Front-end stage that sits ahead of Decode and closes the loop with Execute. It owns the program counter and issues word reads to a synchronous instruction ROM. Returned words are buffered in a small FIFO and handed to Decode over a valid/ready handshake. When Execute signals a taken branch, the stage redirects the PC and flushes every stale instruction.

Parameters:
DEPTH, 2, prefetch FIFO entries (power of two, ≥2)
RESET_PC, 32'h0000_0000, PC value loaded on reset
AW, 32, PC / ROM address width in bits

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  ROM read strobe
imem_addr  out  AW  byte address of the read, word aligned
imem_rdata  in  32  ROM data; valid the cycle after imem_req
out_valid  out  1  head instruction presented to Decode
out_ready  in  1  Decode accepts the head this cycle
out_instr  out  32  instruction word
out_pc  out  AW  byte address of out_instr; carried down the pipe as the branch base
branch_taken  in  1  Execute redirect pulse (driven from global_disable)
branch_delta  in  32  signed offset in instructions (from delta_instruction)
branch_base_pc  in  AW  out_pc tag of the instruction that branched

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC; FIFO empty; inflight=0.
  - imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
  - Reset mid-operation drops all FIFO contents and any in-flight read.
- Credit rule:
  - imem_req=1 in a cycle iff (occupancy + inflight) < DEPTH and branch_taken=0.
  - imem_addr=pc combinationally.
  - On each req: pc += 4 (mod 2^AW); inflight=1 for the next cycle.
- Response capture:
  - A cycle with inflight=1 pushes {imem_rdata, tag pc} into the FIFO, unless killed.
  - Tag = address of the request.
  - The FIFO never overflows because of the credit rule.
- Output:
  - out_valid = FIFO non-empty AND NOT branch_taken (combinational gate).
  - out_instr / out_pc = FIFO head; both are 0 when empty.
  - Pop when out_valid && out_ready.
  - Push and pop may occur in the same cycle; occupancy is then unchanged.
- Branch (branch_taken=1 in cycle N):
  - target = branch_base_pc + (branch_delta << 2), truncated to AW; wrap-around allowed.
  - At edge N: pc=target; FIFO cleared; no pop; no req issued in N.
  - A read in flight during N (issued N-1) is killed: data not pushed, inflight cleared.
  - N+1: req at target. N+2: word pushed. N+3: out_valid=1 with out_pc=target.
  - branch_taken held for consecutive cycles: each cycle re-targets; the last cycle wins.
- Latency:
  - From reset release (first edge = cycle 0): req at RESET_PC in cycle 0, push at edge 1, out_valid in cycle 2.
  - Steady state with out_ready=1: one instruction per cycle.
- Full FIFO with out_ready=0: no req issued; pc holds; out_instr stable.
- Unaligned target (bits[1:0]≠0): bits forced to 0 on imem_addr and pc.
- No other state. The state machine is the implicit pair {FIFO occupancy 0..DEPTH, inflight 0/1}. It transitions only as above.

Test Plan:
- Streaming: ROM[i]=0xA000_0000+i, out_ready=1 after reset → out_valid from cycle 2; out_pc 0,4,8,…; out_instr 0xA000_0000, 0xA000_0001, … one per cycle.
- Backpressure: out_ready=0 from cycle 2 → FIFO fills to DEPTH=2; imem_req=0 after two reqs plus credit limit; pc=8; out_instr holds 0xA000_0000. Releasing ready resumes at out_pc=0,4,8 with no loss or duplicates.
- Forward branch with in-flight read: branch_taken pulse, base=0x10, delta=+5 → stale words never appear; next out_pc=0x24 exactly 3 cycles after the pulse.
- Backward and wrap-around branch: base=0x4, delta=-2 → target 0xFFFF_FFFC; imem_addr=0xFFFF_FFFC; next fetch is 0x0000_0000.
- Branch coincident with out_ready=1 and a non-empty FIFO → out_valid=0 that cycle, no pop; FIFO empty after the edge.
- Async reset asserted mid-stream for half a cycle → all outputs 0 immediately. After release the sequence restarts at RESET_PC with the cycle-2 first valid.
